// File: rtl/snake_body_engine_pkg.sv
// Shared types for the snake body engine.
// Holds direction codes, FSM states and the reverse-direction helper.
package snake_body_engine_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DEAD   = 2'd3
  } state_e;

  // Opposite directions differ only in bit 1.
  function automatic dir_e dir_rev(dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_body_engine_if.sv
// Control/status bundle between game logic and the snake body engine.
// master: game FSM + pixel path (drives step/grow/query); slave: engine.
interface snake_body_engine_if #(
  parameter int COORD_W = 5,
  parameter int LEN_W   = 5
);
  logic               restart;
  logic               step;
  logic [1:0]         dir_req;
  logic               grow;
  logic [COORD_W-1:0] qx;
  logic [COORD_W-1:0] qy;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [1:0]         dir;
  logic [LEN_W-1:0]   len;
  logic               busy;
  logic               moved;
  logic               dead;
  logic               full;
  logic               q_head;
  logic               q_body;

  modport master (
    output restart, step, dir_req, grow, qx, qy,
    input  head_x, head_y, dir, len, busy, moved,
    input  dead, full, q_head, q_body
  );

  modport slave (
    input  restart, step, dir_req, grow, qx, qy,
    output head_x, head_y, dir, len, busy, moved,
    output dead, full, q_head, q_body
  );
endinterface

// File: rtl/snake_next_cell.sv
// Combinational next head cell: head + direction -> cand, wall flag.
// SNAKE_WRAP_EN: edges wrap around and wall is never raised.
module snake_next_cell
  import snake_body_engine_pkg::*;
#(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int COORD_W = 5
) (
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  dir_e               dir,
  output logic [COORD_W-1:0] cand_x,
  output logic [COORD_W-1:0] cand_y,
  output logic               wall
);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

  logic at_edge;

  always_comb begin
    cand_x  = head_x;
    cand_y  = head_y;
    at_edge = 1'b0;
    unique case (dir)
      DIR_RIGHT: begin
        at_edge = (head_x == X_MAX);
        cand_x  = at_edge ? '0 : head_x + ONE;
      end
      DIR_LEFT: begin
        at_edge = (head_x == '0);
        cand_x  = at_edge ? X_MAX : head_x - ONE;
      end
      DIR_UP: begin
        at_edge = (head_y == '0);
        cand_y  = at_edge ? Y_MAX : head_y - ONE;
      end
      DIR_DOWN: begin
        at_edge = (head_y == Y_MAX);
        cand_y  = at_edge ? '0 : head_y + ONE;
      end
      default: ;
    endcase
`ifdef SNAKE_WRAP_EN
    wall = 1'b0;
`else
    wall = at_edge;
`endif
  end
endmodule

// File: rtl/snake_body_engine.sv
// Snake body store + movement FSM with serial self-collision scan.
// Ports: clk, rst (async high), bus (slave). Wrap via SNAKE_WRAP_EN.
module snake_body_engine
  import snake_body_engine_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int COORD_W  = 5,
  parameter int MAX_LEN  = 20,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 8,
  parameter int INIT_Y   = 12
) (
  input logic                clk,
  input logic                rst,
  snake_body_engine_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_INI = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] L1      = LEN_W'(1);

  function automatic logic [COORD_W-1:0] init_x(int i);
    return (i < INIT_LEN) ? COORD_W'(INIT_X - i) : '0;
  endfunction

  function automatic logic [COORD_W-1:0] init_y(int i);
    return (i < INIT_LEN) ? COORD_W'(INIT_Y) : '0;
  endfunction

  state_e             state_q, state_d;
  logic [COORD_W-1:0] seg_x [MAX_LEN];
  logic [COORD_W-1:0] seg_y [MAX_LEN];
  dir_e               dir_q, eff_dir_q, eff_dir;
  logic [LEN_W-1:0]   len_q, lim_q, idx_q, lim_d;
  logic [COORD_W-1:0] cand_x_q, cand_y_q, nx_x, nx_y;
  logic               wall_q, hit_q, nx_wall;
  logic               grow_pend, moved_q;
  logic               q_head_q, q_body_q;
  logic               cmp_hit, last, ok, body_hit;

  // A reversal request keeps the committed direction.
  assign eff_dir = (dir_e'(bus.dir_req) == dir_rev(dir_q))
                 ? dir_q : dir_e'(bus.dir_req);

  // With growth pending the tail stays put, so it must be scanned too.
  assign lim_d   = grow_pend ? len_q : len_q - L1;
  assign cmp_hit = (cand_x_q == seg_x[idx_q])
                && (cand_y_q == seg_y[idx_q]);
  assign last    = (idx_q == lim_q - L1);
  assign ok      = !(wall_q || hit_q);

  snake_next_cell #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .COORD_W(COORD_W)
  ) u_next (
    .head_x(seg_x[0]),
    .head_y(seg_y[0]),
    .dir   (eff_dir),
    .cand_x(nx_x),
    .cand_y(nx_y),
    .wall  (nx_wall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              state_q <= ST_IDLE;
    else if (bus.restart) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (bus.step)
          state_d = (lim_d == '0) ? ST_COMMIT : ST_SCAN;
      ST_SCAN:
        if (last) state_d = ST_COMMIT;
      ST_COMMIT:
        state_d = ok ? ST_IDLE : ST_DEAD;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= init_y(i);
      end
    end else if (bus.restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= init_y(i);
      end
    end else if (state_q == ST_COMMIT && ok) begin
      seg_x[0] <= cand_x_q;
      seg_y[0] <= cand_y_q;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || 1'b0) begin
      dir_q     <= DIR_RIGHT;
      eff_dir_q <= DIR_RIGHT;
      len_q     <= LEN_INI;
      lim_q     <= '0;
      idx_q     <= '0;
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      wall_q    <= 1'b0;
      hit_q     <= 1'b0;
      grow_pend <= 1'b0;
      moved_q   <= 1'b0;
    end else if (bus.restart) begin
      dir_q     <= DIR_RIGHT;
      eff_dir_q <= DIR_RIGHT;
      len_q     <= LEN_INI;
      lim_q     <= '0;
      idx_q     <= '0;
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      wall_q    <= 1'b0;
      hit_q     <= 1'b0;
      grow_pend <= 1'b0;
      moved_q   <= 1'b0;
    end else begin
      moved_q <= 1'b0;
      unique case (state_q)
        ST_IDLE:
          if (bus.step) begin
            cand_x_q  <= nx_x;
            cand_y_q  <= nx_y;
            wall_q    <= nx_wall;
            eff_dir_q <= eff_dir;
            lim_q     <= lim_d;
            idx_q     <= '0;
            hit_q     <= 1'b0;
          end
        ST_SCAN: begin
          if (cmp_hit) hit_q <= 1'b1;
          idx_q <= idx_q + L1;
        end
        ST_COMMIT:
          if (ok) begin
            dir_q <= eff_dir_q;
            if (grow_pend && len_q != LEN_MAX)
              len_q <= len_q + L1;
            grow_pend <= 1'b0;
            moved_q   <= 1'b1;
          end
        default: ;
      endcase
      // A new grow pulse beats the commit clear.
      if (bus.grow && state_q != ST_DEAD)
        grow_pend <= 1'b1;
    end
  end

  always_comb begin
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (LEN_W'(i) < len_q
          && bus.qx == seg_x[i] && bus.qy == seg_y[i])
        body_hit = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_head_q <= 1'b0;
      q_body_q <= 1'b0;
    end else if (bus.restart) begin
      q_head_q <= 1'b0;
      q_body_q <= 1'b0;
    end else begin
      q_head_q <= (bus.qx == seg_x[0]) && (bus.qy == seg_y[0]);
      q_body_q <= body_hit;
    end
  end

  assign bus.head_x = seg_x[0];
  assign bus.head_y = seg_y[0];
  assign bus.dir    = dir_q;
  assign bus.len    = len_q;
  assign bus.busy   = (state_q == ST_SCAN) || (state_q == ST_COMMIT);
  assign bus.moved  = moved_q;
  assign bus.dead   = (state_q == ST_DEAD);
  assign bus.full   = (len_q == LEN_MAX);
  assign bus.q_head = q_head_q;
  assign bus.q_body = q_body_q;
endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine (default grid/length params).
// Wall/wrap expectation follows SNAKE_WRAP_EN.
module tb_snake_body_engine;
  import snake_body_engine_pkg::*;

  typedef struct {
    logic [4:0] hx;
    logic [4:0] hy;
    logic [1:0] d;
    logic [4:0] l;
    logic       dead;
    int         due;
  } exp_t;

  typedef struct {
    logic h;
    logic b;
    int   due;
  } qexp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  logic  dead_prev = 1'b0;
  exp_t  sb[$];
  qexp_t qsb[$];

  snake_body_engine_if #(.COORD_W(5), .LEN_W(5)) bus ();

  snake_body_engine dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: a move pulse or a new death is one scoreboard event.
  always @(negedge clk) begin
    exp_t  e;
    qexp_t q;
    if (!rst) begin
      if (bus.moved || (bus.dead && !dead_prev)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got head %0d,%0d expected none",
                   bus.head_x, bus.head_y);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.due);
          chk("head_x", bus.head_x, e.hx);
          chk("head_y", bus.head_y, e.hy);
          chk("dir", bus.dir, e.d);
          chk("len", bus.len, e.l);
          chk("dead", bus.dead, e.dead);
          chk("moved", bus.moved, !e.dead);
          chk("busy", bus.busy, 0);
          chk("full", bus.full, e.l == 5'd20);
        end
      end
      if (qsb.size() != 0 && qsb[0].due == cyc) begin
        q = qsb.pop_front();
        chk("q_head", bus.q_head, q.h);
        chk("q_body", bus.q_body, q.b);
      end
      dead_prev = bus.dead;
    end
  end

  task automatic do_step(input logic [1:0] d, input logic g,
                         input logic dup, input logic [4:0] ex,
                         input logic [4:0] ey, input logic [1:0] ed,
                         input logic [4:0] el, input logic edead,
                         input int elat);
    exp_t e;
    if (g) begin
      bus.grow = 1'b1;
      @(negedge clk);
      bus.grow = 1'b0;
    end
    e.hx = ex; e.hy = ey; e.d = ed; e.l = el;
    e.dead = edead; e.due = cyc + elat;
    sb.push_back(e);
    bus.dir_req = d;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    if (dup) begin
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
    end
    repeat (elat + 2) @(negedge clk);
  endtask

  task automatic query(input logic [4:0] x, input logic [4:0] y,
                       input logic eh, input logic eb);
    qexp_t q;
    bus.qx = x;
    bus.qy = y;
    q.h = eh; q.b = eb; q.due = cyc + 1;
    qsb.push_back(q);
    @(negedge clk);
  endtask

  task automatic check_init(input string tag);
    chk({tag, "_head_x"}, bus.head_x, 8);
    chk({tag, "_head_y"}, bus.head_y, 12);
    chk({tag, "_dir"}, bus.dir, DIR_RIGHT);
    chk({tag, "_len"}, bus.len, 3);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_dead"}, bus.dead, 0);
    chk({tag, "_full"}, bus.full, 0);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  initial begin
    exp_t e;
    bus.restart = 1'b0;
    bus.step = 1'b0;
    bus.dir_req = DIR_RIGHT;
    bus.grow = 1'b0;
    bus.qx = '0;
    bus.qy = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_init("reset");
    chk("reset_moved", bus.moved, 0);
    chk("reset_q_head", bus.q_head, 0);
    chk("reset_q_body", bus.q_body, 0);

    query(8, 12, 1, 0);
    query(7, 12, 0, 1);
    query(6, 12, 0, 1);
    query(9, 12, 0, 0);
    query(0, 0, 0, 0);

    do_step(DIR_RIGHT, 0, 0, 9, 12, DIR_RIGHT, 3, 0, 4);
    do_step(DIR_RIGHT, 0, 1, 10, 12, DIR_RIGHT, 3, 0, 4);
    do_step(DIR_RIGHT, 0, 0, 11, 12, DIR_RIGHT, 3, 0, 4);
    do_step(DIR_LEFT, 0, 0, 12, 12, DIR_RIGHT, 3, 0, 4);
    query(12, 12, 1, 0);
    query(10, 12, 0, 1);
    query(9, 12, 0, 0);

    do_step(DIR_RIGHT, 1, 0, 13, 12, DIR_RIGHT, 4, 0, 5);
    do_step(DIR_UP, 1, 0, 13, 11, DIR_UP, 5, 0, 6);
    do_step(DIR_LEFT, 0, 0, 12, 11, DIR_LEFT, 5, 0, 6);
    do_step(DIR_DOWN, 0, 0, 12, 11, DIR_LEFT, 5, 1, 6);
    query(12, 12, 0, 1);

    bus.dir_req = DIR_UP;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("dead_step_busy", bus.busy, 0);
    repeat (10) @(negedge clk);
    chk("dead_sticky", bus.dead, 1);
    chk("dead_head_y", bus.head_y, 11);

    do_restart();
    check_init("restart");

    // Abort mid-scan with growth pending.
    bus.grow = 1'b1;
    @(negedge clk);
    bus.grow = 1'b0;
    bus.dir_req = DIR_RIGHT;
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("scan_busy", bus.busy, 1);
    do_restart();
    repeat (10) @(negedge clk);
    check_init("abort");

    // Grow during COMMIT applies to the following move.
    e.hx = 9; e.hy = 12; e.d = DIR_RIGHT; e.l = 3;
    e.dead = 0; e.due = cyc + 4;
    sb.push_back(e);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (2) @(negedge clk);
    bus.grow = 1'b1;
    @(negedge clk);
    bus.grow = 1'b0;
    repeat (3) @(negedge clk);
    do_step(DIR_RIGHT, 0, 0, 10, 12, DIR_RIGHT, 4, 0, 5);

    for (int k = 4; k < 20; k++)
      do_step(DIR_RIGHT, 1, 0, 5'(10 + k - 3), 12, DIR_RIGHT,
              5'(k + 1), 0, k + 2);
    do_step(DIR_RIGHT, 1, 0, 27, 12, DIR_RIGHT, 20, 0, 22);
    for (int x = 28; x < 32; x++)
      do_step(DIR_RIGHT, 0, 0, 5'(x), 12, DIR_RIGHT, 20, 0, 21);
`ifdef SNAKE_WRAP_EN
    do_step(DIR_RIGHT, 0, 0, 0, 12, DIR_RIGHT, 20, 0, 21);
`else
    do_step(DIR_RIGHT, 0, 0, 31, 12, DIR_RIGHT, 20, 1, 21);
`endif

    repeat (5) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: got none expected head %0d,%0d",
               e.hx, e.hy);
    end
    while (qsb.size() != 0) begin
      void'(qsb.pop_front());
      checks++;
      errors++;
      $display("FAIL missing_query: got none expected one result");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
